// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter: sequencer states and default sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 8192;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after 'last', wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  winner_oh,
  output logic [IW-1:0] winner_idx,
  output logic          valid
);

  always_comb begin
    logic [IW-1:0] k;
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    k          = '0;
    // Offset 1..N visits last+1 first and last itself at the very end.
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(last) + i) % N);
      if (!valid && req[k]) begin
        valid        = 1'b1;
        winner_idx   = k;
        winner_oh[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte sources, with a
// watchdog that abandons a transfer if the transmitter never reports done.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                        I_CLK,
  input  logic                        I_RSTF,
  input  logic [NUM_REQ-1:0]          I_REQ,
  input  logic [NUM_REQ*DATA_W-1:0]   I_DATA,
  output logic [NUM_REQ-1:0]          O_GRANT,
  output logic                        O_TX_START,
  output logic [DATA_W-1:0]           O_TX_DATA,
  input  logic                        I_TX_DONE,
  output logic                        O_BUSY,
  output logic [$clog2(NUM_REQ)-1:0]  O_OWNER,
  output logic                        O_TIMEOUT
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [IW-1:0]   LAST_RST = IW'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                busy_q, busy_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic                timeout_q, timeout_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [IW-1:0]       last_q, last_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic [DATA_W-1:0]   pick_data;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
    .req        (I_REQ),
    .last       (last_q),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // One-hot AND-OR mux keeps the byte select free of a wide index multiply.
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_oh[k]) pick_data = pick_data | I_DATA[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    timeout_d  = 1'b0;
    wd_d       = wd_q;
    last_d     = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d   = pick_oh;
          tx_data_d = pick_data;
          owner_d   = pick_idx;
          last_d    = pick_idx;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        tx_start_d = 1'b1;
        wd_d       = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // Done takes priority over a coincident watchdog expiry.
        if (I_TX_DONE) begin
          state_d = ST_IDLE;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      owner_q    <= '0;
      timeout_q  <= 1'b0;
      wd_q       <= '0;
      last_q     <= LAST_RST;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      timeout_q  <= timeout_d;
      wd_q       <= wd_d;
      last_q     <= last_d;
    end
  end

  assign O_GRANT    = grant_q;
  assign O_TX_START = tx_start_q;
  assign O_TX_DATA  = tx_data_q;
  assign O_BUSY     = busy_q;
  assign O_OWNER    = owner_q;
  assign O_TIMEOUT  = timeout_q;

endmodule
